// File: rtl/keystream_packer.sv
// Packs the serial keystream into W-bit words and queues them in a FWFT FIFO.
// Latency: word visible the cycle after its last bit when the FIFO was empty.
// Backpressure: the generator never stalls; a word that arrives at a full FIFO with no pop is dropped and counted.

module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same edge.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module keystream_packer #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int LVL_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [0:W-1]     word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [LVL_W-1:0] fill_level,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count
);
    localparam int BW = $clog2(W);

    logic [BW-1:0] bit_cnt;
    logic [0:W-2]  shreg;
    logic          last_bit;
    logic          push;
    logic          pop;
    logic          drop;
    logic          full;
    logic          empty;
    logic [W-1:0]  word;
    logic [W-1:0]  head;

    assign last_bit   = (bit_cnt == BW'(W-1));
    assign push       = bit_valid && last_bit && !clr;
    assign word       = {shreg, bit_in};
    assign pop        = word_ready && !clr;
    assign drop       = push && full && !(pop && !empty);
    assign word_valid = !empty;
    assign word_out   = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (clr) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (bit_valid) begin
            // The final bit goes straight into the pushed word, never into shreg.
            if (last_bit) begin
                bit_cnt <= '0;
            end else begin
                shreg[bit_cnt] <= bit_in;
                bit_cnt        <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    sync_fifo #(
        .DW    (W),
        .DEPTH (DEPTH),
        .CW    (LVL_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .push     (push),
        .push_dat (word),
        .pop      (pop),
        .head_dat (head),
        .count    (fill_level),
        .full     (full),
        .empty    (empty)
    );
endmodule

// File: tb/tb_keystream_packer.sv
// Scoreboarded bench for keystream_packer: directed scenarios then random traffic vs a queue-level model.
module tb_keystream_packer;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int LVL_W = 3;
    localparam int CNT_W = 8;

    typedef logic [0:W-1] word_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             bit_in;
    logic             bit_valid;
    word_t            word_out;
    logic             word_valid;
    logic             word_ready;
    logic [LVL_W-1:0] fill_level;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;

    keystream_packer #(.W(W), .DEPTH(DEPTH), .LVL_W(LVL_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fill_level (fill_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    word_t exp_q[$];
    word_t mq[$];
    bit    bits_q[$];
    int    m_ovf;
    int    m_drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        bits_q.delete();
        m_ovf   = 0;
        m_drops = 0;
    endtask

    // Model of one clock edge: bits accumulate in a list, W of them form a word, the queue holds DEPTH words.
    task automatic model_edge(input logic b, input logic v, input logic rdy, input logic c);
        word_t w;
        if (c) begin
            model_clear();
            return;
        end
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (v) begin
            bits_q.push_back(b);
            if (bits_q.size() == W) begin
                for (int i = 0; i < W; i++) w[i] = bits_q[i];
                bits_q.delete();
                if (mq.size() < DEPTH) begin
                    mq.push_back(w);
                    exp_q.push_back(w);
                end else begin
                    m_ovf = 1;
                    if (m_drops < (1 << CNT_W) - 1) m_drops++;
                end
            end
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; state is checked on the falling edge.
    task automatic step(input logic b, input logic v, input logic rdy, input logic c);
        bit_in     = b;
        bit_valid  = v;
        word_ready = rdy;
        clr        = c;
        @(negedge clk);
        chk("word_valid", word_valid, mq.size() != 0);
        chk("fill_level", fill_level, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_drops);
        @(posedge clk);
        model_edge(b, v, rdy, c);
        #1;
    endtask

    task automatic feed_word(input word_t w, input logic rdy);
        for (int i = 0; i < W; i++) step(w[i], 1'b1, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word_unexpected: got %b with no word expected", word_out);
            end else begin
                chk("word_out", word_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        word_t w;
        rst_n      = 1'b0;
        clr        = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        word_ready = 1'b0;
        model_clear();
        #1;
        chk("rst_word_valid", word_valid, 0);
        chk("rst_word_out", word_out, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drops", drop_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: basic packing and latency
        w = 8'b10110010;
        feed_word(w, 1'b1);
        chk("t1_valid", word_valid, 1);
        chk("t1_word", word_out, 32'hB2);
        chk("t1_fill", fill_level, 1);
        idle(2, 1'b1);

        // 2: gaps with bit_in=1 are ignored
        for (int i = 0; i < W; i++) begin
            step(w[i], 1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b1, 1'b0);
        end
        idle(2, 1'b1);

        // 3: overflow on the fifth word, then drain
        for (int k = 1; k <= 5; k++) begin
            w = word_t'(k);
            feed_word(w, 1'b0);
        end
        chk("t3_fill", fill_level, 4);
        chk("t3_overflow", overflow, 1);
        chk("t3_drops", drop_count, 1);
        idle(6, 1'b1);
        chk("t3_drained", fill_level, 0);

        // 4: full FIFO with a pop in the completion cycle of a fifth word
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 'h11; k <= 'h14; k++) begin
            w = word_t'(k);
            feed_word(w, 1'b0);
        end
        w = 8'h15;
        for (int i = 0; i < W; i++) step(w[i], 1'b1, i == W - 1, 1'b0);
        chk("t4_fill", fill_level, 4);
        chk("t4_overflow", overflow, 0);
        chk("t4_drops", drop_count, 0);
        idle(6, 1'b1);

        // 5: clr mid-word discards partial bits and the clr-cycle bit
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t5_fill", fill_level, 0);
        chk("t5_overflow", overflow, 0);
        w = 8'b11110000;
        feed_word(w, 1'b1);
        chk("t5_word", word_out, 32'hF0);
        idle(2, 1'b1);

        // 6: asynchronous reset with two words buffered and five bits pending
        w = 8'h3C;
        feed_word(w, 1'b0);
        w = 8'h5A;
        feed_word(w, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        bit_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", word_valid, 0);
        chk("t6_fill", fill_level, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_drops", drop_count, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        w = 8'hA5;
        feed_word(w, 1'b1);
        chk("t6_word", word_out, 32'hA5);
        idle(2, 1'b1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
                 1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);
        end
        idle(DEPTH + 2, 1'b1);
        chk("final_fill", fill_level, 0);
        chk("final_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
